game_turn_ctl: RTL
==================

Name: game_turn_ctl

Overview:
Sequences a two-player tic-tac-toe match once the start/choice screens hand over to the board.
- Turns left-button presses on the 3x3 on-screen grid into moves.
- Owns the 9-cell board register and alternates the active player.
- Detects win, draw and illegal moves, and gates re-arming on button release.
- Sits between the mouse interface and the board/status drawing blocks.

Parameters:
GRID_X0, 362, x of grid left edge (pixels)
GRID_Y0, 234, y of grid top edge (pixels)
CELL_SIZE, 100, cell width/height (pixels)
RELEASE_CYCLES, 65000, consecutive low samples of mouse_left required to re-arm
TIMEOUT_CYCLES, 650000000, turn time limit (used only with GAME_TURN_TIMEOUT_EN)

Ports:
pclk  in  1  pixel clock; sole clock
rst  in  1  synchronous active-high reset
start_en  in  1  game enabled; low forces IDLE
first_player  in  1  player moving first (0 = X, 1 = O); sampled on IDLE exit
mouse_xpos  in  12  cursor x
mouse_ypos  in  12  cursor y
mouse_left  in  1  left button level
board  out  18  cell i at [2i+1:2i], i = row*3+col; 00 empty, 01 X, 10 O
cur_player  out  1  player to move
game_over  out  1  match finished
winner  out  2  01 X, 10 O, 00 none
draw  out  1  board full, no winner
illegal_move  out  1  one-cycle pulse on a rejected press
turn_timeout  out  1  one-cycle pulse on forced turn pass; tied 0 when feature is off

Behaviour:
- Synchronous active-high reset on pclk. Reset drives all outputs to 0, move_count = 0, state = IDLE.
- Press edge: mouse_left registered into left_d; press = mouse_left & ~left_d.
- Hit decode uses comparators only, no dividers. Inside grid means x in [GRID_X0, GRID_X0+3*CELL_SIZE-1] and y likewise, inclusive. col = 0/1/2 by comparison against GRID_X0+CELL_SIZE and GRID_X0+2*CELL_SIZE; row likewise.
- States: IDLE, WAIT_PRESS, PLACE, CHECK, RELEASE, OVER.
- IDLE: on start_en = 1, clear board, winner, draw, game_over and move_count; cur_player <= first_player; go to WAIT_PRESS.
- WAIT_PRESS:
  - press inside grid on an empty cell: capture cell index, go to PLACE.
  - press outside grid or on an occupied cell: illegal_move = 1 for one cycle, stay.
- PLACE: write cur_player's code (X = 01, O = 10) into the captured cell; move_count + 1; go to CHECK.
- CHECK: evaluate 3 rows, 3 columns and 2 diagonals on the updated board.
  - Line of cur_player's code: winner <= code, game_over <= 1, go to OVER.
  - Else if move_count == 9: draw <= 1, game_over <= 1, go to OVER. A win on the 9th move takes priority over draw.
  - Else: toggle cur_player, go to RELEASE.
- RELEASE: a counter counts cycles with mouse_left = 0 and resets to 0 whenever mouse_left = 1. When it reaches RELEASE_CYCLES-1, go to WAIT_PRESS.
- OVER: hold board and all flags; presses are ignored and do not pulse illegal_move.
- start_en = 0 in any non-IDLE state: go to IDLE next cycle. Board and flags are kept until the next start.
- Latency, with the press sampled at cycle n:
  - state = PLACE at n+1.
  - board updated at n+2.
  - cur_player, game_over, winner and draw updated at n+3.
- A press arriving in PLACE, CHECK, RELEASE or OVER is ignored.

Optional Feature:
GAME_TURN_TIMEOUT_EN
- Defined:
  - A turn counter runs in WAIT_PRESS and clears on entry to WAIT_PRESS.
  - Reaching TIMEOUT_CYCLES-1 with no accepted press: toggle cur_player, pulse turn_timeout for one cycle, restart the counter, stay in WAIT_PRESS.
  - A timeout and a press in the same cycle: the press wins and no timeout occurs.
- Undefined: no counter is built, turn_timeout is tied 0, and a turn never expires.

Test Plan:
Default parameters, RELEASE_CYCLES = 4 and TIMEOUT_CYCLES = 20 for simulation.
1. rst, then start_en = 1, first_player = 0, press at (412,284) -> board = 18'h00001 at n+2, cur_player = 1 at n+3.
2. X plays cells 0, 1, 2 and O plays cells 3, 4, with releases between -> winner = 01, game_over = 1 three cycles after X's press on cell 2; later presses leave board unchanged.
3. Press at (361,284), then press on an occupied cell -> illegal_move pulses once each; board and cur_player unchanged.
4. Full board X,O,X / X,O,O / O,X,X -> draw = 1, winner = 00, game_over = 1 after the 9th move.
5. Hold mouse_left high after a move, with glitch lows shorter than 4 cycles -> stays in RELEASE; a second press is only accepted after 4 consecutive low cycles.
6. GAME_TURN_TIMEOUT_EN defined, no press for 20 cycles in WAIT_PRESS -> turn_timeout pulses and cur_player toggles; drop start_en mid-game -> IDLE next cycle with board retained.

Source files
------------

// File: rtl/game_turn_ctl.sv
// rtl/game_turn_ctl.sv - two-player tic-tac-toe turn sequencer: press decode, board, win/draw detection
// Optional per-turn time limit enabled by defining GAME_TURN_TIMEOUT_EN.
module game_turn_ctl #(
  parameter int GRID_X0        = 362,
  parameter int GRID_Y0        = 234,
  parameter int CELL_SIZE      = 100,
  parameter int RELEASE_CYCLES = 65000,
  parameter int TIMEOUT_CYCLES = 650000000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start_en,
  input  logic        first_player,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [17:0] board,
  output logic        cur_player,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        illegal_move,
  output logic        turn_timeout
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PRESS, S_PLACE, S_CHECK, S_RELEASE, S_OVER
  } state_t;

  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [11:0] X_LO = 12'(GRID_X0);
  localparam logic [11:0] X_M1 = 12'(GRID_X0 + CELL_SIZE);
  localparam logic [11:0] X_M2 = 12'(GRID_X0 + 2 * CELL_SIZE);
  localparam logic [11:0] X_HI = 12'(GRID_X0 + 3 * CELL_SIZE - 1);
  localparam logic [11:0] Y_LO = 12'(GRID_Y0);
  localparam logic [11:0] Y_M1 = 12'(GRID_Y0 + CELL_SIZE);
  localparam logic [11:0] Y_M2 = 12'(GRID_Y0 + 2 * CELL_SIZE);
  localparam logic [11:0] Y_HI = 12'(GRID_Y0 + 3 * CELL_SIZE - 1);

  state_t           r_state, w_next;
  logic [17:0]      r_board;
  logic [1:0]       r_winner;
  logic             r_cur_player, r_game_over, r_draw, r_illegal, r_left_d;
  logic [3:0]       r_move_count, r_cell;
  logic [REL_W-1:0] r_rel_cnt;

  logic       w_press, w_in_grid, w_cell_free, w_win, w_to_hit;
  logic [1:0] w_col, w_row, w_code;
  logic [3:0] w_cell_idx;
  logic       w_do_start, w_accept, w_reject, w_place, w_check;

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] c);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == c);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  assign w_press     = mouse_left & ~r_left_d;
  assign w_in_grid   = (mouse_xpos >= X_LO) && (mouse_xpos <= X_HI) &&
                       (mouse_ypos >= Y_LO) && (mouse_ypos <= Y_HI);
  assign w_col       = (mouse_xpos < X_M1) ? 2'd0 : (mouse_xpos < X_M2) ? 2'd1 : 2'd2;
  assign w_row       = (mouse_ypos < Y_M1) ? 2'd0 : (mouse_ypos < Y_M2) ? 2'd1 : 2'd2;
  assign w_cell_idx  = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
  assign w_cell_free = (r_board[{w_cell_idx, 1'b0} +: 2] == 2'b00);
  assign w_code      = r_cur_player ? 2'b10 : 2'b01;
  assign w_win       = has_line(r_board, w_code);

  always_ff @(posedge pclk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Dropping start_en abandons any state but IDLE on the next edge.
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && !start_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (start_en) w_next = S_WAIT_PRESS;
        S_WAIT_PRESS: if (w_accept) w_next = S_PLACE;
        S_PLACE:      w_next = S_CHECK;
        S_CHECK:      w_next = (w_win || r_move_count == 4'd9) ? S_OVER : S_RELEASE;
        S_RELEASE:    if (!mouse_left && r_rel_cnt == REL_LAST) w_next = S_WAIT_PRESS;
        S_OVER:       w_next = S_OVER;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_do_start = 1'b0;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    w_place    = 1'b0;
    w_check    = 1'b0;
    if (start_en) begin
      case (r_state)
        S_IDLE:       w_do_start = 1'b1;
        S_WAIT_PRESS: begin
          w_accept = w_press & w_in_grid & w_cell_free;
          w_reject = w_press & ~(w_in_grid & w_cell_free);
        end
        S_PLACE:      w_place = 1'b1;
        S_CHECK:      w_check = 1'b1;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_board      <= '0;
      r_winner     <= 2'b00;
      r_cur_player <= 1'b0;
      r_game_over  <= 1'b0;
      r_draw       <= 1'b0;
      r_illegal    <= 1'b0;
      r_left_d     <= 1'b0;
      r_move_count <= '0;
      r_cell       <= '0;
      r_rel_cnt    <= '0;
    end else begin
      r_left_d  <= mouse_left;
      r_illegal <= w_reject;
      if (r_state == S_RELEASE && !mouse_left) r_rel_cnt <= r_rel_cnt + REL_W'(1);
      else                                     r_rel_cnt <= '0;
      if (w_do_start) begin
        r_board      <= '0;
        r_winner     <= 2'b00;
        r_draw       <= 1'b0;
        r_game_over  <= 1'b0;
        r_move_count <= '0;
        r_cur_player <= first_player;
      end
      if (w_accept) r_cell <= w_cell_idx;
      if (w_place) begin
        r_board[{r_cell, 1'b0} +: 2] <= w_code;
        r_move_count                 <= r_move_count + 4'd1;
      end
      // A completed line on the ninth move is a win, not a draw.
      if (w_check) begin
        if (w_win) begin
          r_winner    <= w_code;
          r_game_over <= 1'b1;
        end else if (r_move_count == 4'd9) begin
          r_draw      <= 1'b1;
          r_game_over <= 1'b1;
        end else begin
          r_cur_player <= ~r_cur_player;
        end
      end
      if (w_to_hit) r_cur_player <= ~r_cur_player;
    end
  end

`ifdef GAME_TURN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // An accepted press in the expiry cycle suppresses the timeout.
  assign w_to_hit = (r_state == S_WAIT_PRESS) && start_en && !w_accept && (r_to_cnt == TO_LAST);

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (r_state != S_WAIT_PRESS || w_to_hit) r_to_cnt <= '0;
      else                                     r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
  assign turn_timeout = r_timeout;
`else
  assign w_to_hit     = 1'b0;
  assign turn_timeout = 1'b0;
`endif

  assign board        = r_board;
  assign cur_player   = r_cur_player;
  assign game_over    = r_game_over;
  assign winner       = r_winner;
  assign draw         = r_draw;
  assign illegal_move = r_illegal;
endmodule
